// File: rtl/pipe_ctrl_unit.sv
// rtl/pipe_ctrl_unit.sv - 5-stage MIPS pipeline control: ID decode, ID/EX, EX/MEM, MEM/WB control registers, load-use stall, flush.
// Optional stall/flush/illegal counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl_unit #(
  parameter int ALU_OP_W  = 5,
  parameter int BR_TYPE_W = 3,
  parameter int REG_AW    = 5,
  parameter int LINK_REG  = 31
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          instr_i,
  input  logic                 id_valid_i,
  input  logic                 branch_taken_i,
  output logic [ALU_OP_W-1:0]  ex_alu_op_o,
  output logic                 ex_alusrc_o,
  output logic                 ex_branch_o,
  output logic [BR_TYPE_W-1:0] ex_brtype_o,
  output logic                 mem_read_o,
  output logic                 mem_write_o,
  output logic                 mem_branch_o,
  output logic                 wb_regwrite_o,
  output logic [1:0]           wb_memtoreg_o,
  output logic [REG_AW-1:0]    wb_dst_o,
  output logic [1:0]           id_jump_o,
  output logic                 pc_write_o,
  output logic                 ifid_write_o,
  output logic                 ifid_flush_o,
  output logic                 illegal_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]          stall_cnt_o,
  output logic [31:0]          flush_cnt_o,
  output logic [31:0]          illegal_cnt_o
`endif
);

  typedef struct packed {
    logic [ALU_OP_W-1:0]  alu_op;
    logic                 alusrc;
    logic                 branch;
    logic [BR_TYPE_W-1:0] brtype;
    logic                 mem_read;
    logic                 mem_write;
    logic                 regwrite;
    logic [1:0]           memtoreg;
    logic [REG_AW-1:0]    dst;
  } idex_t;

  typedef struct packed {
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              regwrite;
    logic [1:0]        memtoreg;
    logic [REG_AW-1:0] dst;
  } exmem_t;

  typedef struct packed {
    logic              regwrite;
    logic [1:0]        memtoreg;
    logic [REG_AW-1:0] dst;
  } memwb_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLT   = 6'h06;
  localparam logic [5:0] OP_BLE   = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic              unused_shamt;

  assign opcode       = instr_i[31:26];
  assign funct        = instr_i[5:0];
  assign rs           = REG_AW'(instr_i[25:21]);
  assign rt           = REG_AW'(instr_i[20:16]);
  assign rd           = REG_AW'(instr_i[15:11]);
  assign unused_shamt = ^instr_i[10:6];

  idex_t      dec_raw;
  idex_t      dec;
  logic [1:0] jump_raw;
  logic [1:0] jump;
  logic       uses_rs_raw;
  logic       uses_rt_raw;
  logic       uses_rs;
  logic       uses_rt;
  logic       legal;

  always_comb begin
    dec_raw     = '0;
    jump_raw    = 2'd0;
    uses_rs_raw = 1'b0;
    uses_rt_raw = 1'b0;
    legal       = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        dec_raw.alu_op = ALU_OP_W'(2);
        uses_rs_raw    = 1'b1;
        if (funct == FN_JR) begin
          jump_raw = 2'd2;
        end else begin
          dec_raw.regwrite = 1'b1;
          dec_raw.dst      = rd;
          uses_rt_raw      = 1'b1;
        end
      end
      OP_ADDI: begin
        dec_raw.alu_op   = ALU_OP_W'(0);
        dec_raw.alusrc   = 1'b1;
        dec_raw.regwrite = 1'b1;
        dec_raw.dst      = rt;
        uses_rs_raw      = 1'b1;
      end
      OP_ORI: begin
        dec_raw.alu_op   = ALU_OP_W'(4);
        dec_raw.alusrc   = 1'b1;
        dec_raw.regwrite = 1'b1;
        dec_raw.dst      = rt;
        uses_rs_raw      = 1'b1;
      end
      OP_LUI: begin
        dec_raw.alu_op   = ALU_OP_W'(5);
        dec_raw.alusrc   = 1'b1;
        dec_raw.regwrite = 1'b1;
        dec_raw.dst      = rt;
      end
      OP_LW: begin
        dec_raw.alu_op   = ALU_OP_W'(6);
        dec_raw.alusrc   = 1'b1;
        dec_raw.mem_read = 1'b1;
        dec_raw.memtoreg = 2'd1;
        dec_raw.regwrite = 1'b1;
        dec_raw.dst      = rt;
        uses_rs_raw      = 1'b1;
      end
      OP_SW: begin
        dec_raw.alu_op    = ALU_OP_W'(7);
        dec_raw.alusrc    = 1'b1;
        dec_raw.mem_write = 1'b1;
        uses_rs_raw       = 1'b1;
        uses_rt_raw       = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLE, OP_BLT: begin
        dec_raw.branch = 1'b1;
        uses_rs_raw    = 1'b1;
        uses_rt_raw    = 1'b1;
        case (opcode)
          OP_BEQ: begin
            dec_raw.alu_op = ALU_OP_W'(1);
            dec_raw.brtype = BR_TYPE_W'(1);
          end
          OP_BNE: begin
            dec_raw.alu_op = ALU_OP_W'(3);
            dec_raw.brtype = BR_TYPE_W'(2);
          end
          OP_BLE: begin
            dec_raw.alu_op = ALU_OP_W'(10);
            dec_raw.brtype = BR_TYPE_W'(3);
          end
          default: begin
            dec_raw.alu_op = ALU_OP_W'(11);
            dec_raw.brtype = BR_TYPE_W'(4);
          end
        endcase
      end
      OP_J: begin
        dec_raw.alu_op = ALU_OP_W'(8);
        jump_raw       = 2'd1;
      end
      OP_JAL: begin
        dec_raw.alu_op   = ALU_OP_W'(9);
        dec_raw.regwrite = 1'b1;
        dec_raw.dst      = REG_AW'(LINK_REG);
        dec_raw.memtoreg = 2'd2;
        jump_raw         = 2'd1;
      end
      default: legal = 1'b0;
    endcase
    // $0 is hardwired, so a write to it is dropped at decode
    if (dec_raw.dst == '0) dec_raw.regwrite = 1'b0;
  end

  // An invalid ID slot decodes as a bubble
  assign dec       = id_valid_i ? dec_raw : '0;
  assign jump      = id_valid_i ? jump_raw : 2'd0;
  assign uses_rs   = id_valid_i & uses_rs_raw;
  assign uses_rt   = id_valid_i & uses_rt_raw;
  assign illegal_o = ~legal;

  idex_t  idex_q;
  exmem_t exmem_q;
  memwb_t memwb_q;
  logic   load_use;
  logic   stall;

  assign load_use = idex_q.mem_read && (idex_q.dst != '0) &&
                    ((uses_rs && (idex_q.dst == rs)) || (uses_rt && (idex_q.dst == rt)));
  // A taken branch squashes the dependent instruction anyway, so it overrides the stall
  assign stall        = load_use & ~branch_taken_i;
  assign pc_write_o   = ~stall;
  assign ifid_write_o = ~stall;
  assign id_jump_o    = stall ? 2'd0 : jump;
  assign ifid_flush_o = branch_taken_i | ((jump != 2'd0) & ~stall);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      if (branch_taken_i || stall) begin
        idex_q <= '0;
      end else begin
        idex_q <= dec;
      end
      if (branch_taken_i) begin
        exmem_q <= '0;
      end else begin
        exmem_q.mem_read  <= idex_q.mem_read;
        exmem_q.mem_write <= idex_q.mem_write;
        exmem_q.branch    <= idex_q.branch;
        exmem_q.regwrite  <= idex_q.regwrite;
        exmem_q.memtoreg  <= idex_q.memtoreg;
        exmem_q.dst       <= idex_q.dst;
      end
      memwb_q.regwrite <= exmem_q.regwrite;
      memwb_q.memtoreg <= exmem_q.memtoreg;
      memwb_q.dst      <= exmem_q.dst;
    end
  end

  assign ex_alu_op_o   = idex_q.alu_op;
  assign ex_alusrc_o   = idex_q.alusrc;
  assign ex_branch_o   = idex_q.branch;
  assign ex_brtype_o   = idex_q.brtype;
  assign mem_read_o    = exmem_q.mem_read;
  assign mem_write_o   = exmem_q.mem_write;
  assign mem_branch_o  = exmem_q.branch;
  assign wb_regwrite_o = memwb_q.regwrite;
  assign wb_memtoreg_o = memwb_q.memtoreg;
  assign wb_dst_o      = memwb_q.dst;

`ifdef PIPE_CTRL_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;
  logic [31:0] illegal_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      illegal_cnt_q <= '0;
    end else begin
      stall_cnt_q   <= sat_inc(stall_cnt_q, stall);
      flush_cnt_q   <= sat_inc(flush_cnt_q, ifid_flush_o);
      illegal_cnt_q <= sat_inc(illegal_cnt_q, illegal_o & id_valid_i);
    end
  end

  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;
  assign illegal_cnt_o = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb/tb_pipe_ctrl_unit.sv - scoreboard bench for pipe_ctrl_unit against a table-driven pipeline model.
module tb_pipe_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] instr_i;
  logic        id_valid_i;
  logic        branch_taken_i;
  logic [4:0]  ex_alu_op_o;
  logic        ex_alusrc_o;
  logic        ex_branch_o;
  logic [2:0]  ex_brtype_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic        mem_branch_o;
  logic        wb_regwrite_o;
  logic [1:0]  wb_memtoreg_o;
  logic [4:0]  wb_dst_o;
  logic [1:0]  id_jump_o;
  logic        pc_write_o;
  logic        ifid_write_o;
  logic        ifid_flush_o;
  logic        illegal_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;
  logic [31:0] illegal_cnt_o;
`endif

  always #5 clk = ~clk;

  pipe_ctrl_unit dut (
    .clk_i(clk), .rst_i(rst_i), .instr_i(instr_i), .id_valid_i(id_valid_i),
    .branch_taken_i(branch_taken_i), .ex_alu_op_o(ex_alu_op_o), .ex_alusrc_o(ex_alusrc_o),
    .ex_branch_o(ex_branch_o), .ex_brtype_o(ex_brtype_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .mem_branch_o(mem_branch_o), .wb_regwrite_o(wb_regwrite_o),
    .wb_memtoreg_o(wb_memtoreg_o), .wb_dst_o(wb_dst_o), .id_jump_o(id_jump_o),
    .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o), .ifid_flush_o(ifid_flush_o),
    .illegal_o(illegal_o)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o), .illegal_cnt_o(illegal_cnt_o)
`endif
  );

  typedef struct {
    int op; int funct; int alu; int src; int br; int brt; int mr;
    int mw; int rw; int m2r; int dsel; int jmp; int urs; int urt;
  } row_t;

  typedef struct {
    int alu_op; int alusrc; int branch; int brtype; int mem_read; int mem_write;
    int regwrite; int memtoreg; int dst; int jump; int urs; int urt; int rs; int rt; int illegal;
  } rec_t;

  typedef struct {
    int ex_alu_op; int ex_alusrc; int ex_branch; int ex_brtype; int mem_read; int mem_write;
    int mem_branch; int wb_regwrite; int wb_memtoreg; int wb_dst; int id_jump; int pc_write;
    int ifid_write; int ifid_flush; int illegal; int stall_cnt; int flush_cnt; int illegal_cnt;
  } exp_t;

  row_t tbl[13];
  int   ops[15] = '{'h00, 'h08, 'h0D, 'h0F, 'h23, 'h2B, 'h04, 'h05, 'h07, 'h06, 'h02, 'h03,
                    'h3F, 'h01, 'h10};
  exp_t exp_q[$];
  rec_t ex_r, mem_r, wb_r;
  bit   in_reset;
  bit   last_stall;
  int   stall_m, flush_m, illegal_m;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: actual %0d required %0d", name, $time, act, req);
    end
  endtask

  // dsel: 0 none, 1 rt, 2 rd, 3 link register; first matching row wins (JR before generic R-type)
  function automatic rec_t decode(input logic [31:0] ins, input bit v);
    rec_t r;
    int op, fn, idx;
    r = '{default: 0};
    op = int'(ins[31:26]);
    fn = int'(ins[5:0]);
    idx = -1;
    for (int i = 0; i < 13; i++)
      if (idx < 0 && tbl[i].op == op && (tbl[i].funct < 0 || tbl[i].funct == fn)) idx = i;
    r.illegal = (idx < 0) ? 1 : 0;
    if (idx < 0 || !v) return r;
    r.alu_op    = tbl[idx].alu;
    r.alusrc    = tbl[idx].src;
    r.branch    = tbl[idx].br;
    r.brtype    = tbl[idx].brt;
    r.mem_read  = tbl[idx].mr;
    r.mem_write = tbl[idx].mw;
    r.memtoreg  = tbl[idx].m2r;
    r.jump      = tbl[idx].jmp;
    r.urs       = tbl[idx].urs;
    r.urt       = tbl[idx].urt;
    r.rs        = int'(ins[25:21]);
    r.rt        = int'(ins[20:16]);
    case (tbl[idx].dsel)
      1: r.dst = int'(ins[20:16]);
      2: r.dst = int'(ins[15:11]);
      3: r.dst = 31;
      default: r.dst = 0;
    endcase
    r.regwrite = (tbl[idx].rw != 0 && r.dst != 0) ? 1 : 0;
    return r;
  endfunction

  task automatic evaluate(input logic [31:0] ins, input bit v, input bit bt);
    rec_t d, bub;
    exp_t e;
    bit hz, st;
    bub = '{default: 0};
    d = decode(ins, v);
    hz = ex_r.mem_read != 0 && ex_r.dst != 0 &&
         ((d.urs != 0 && ex_r.dst == d.rs) || (d.urt != 0 && ex_r.dst == d.rt));
    st = hz && !bt;
    e.ex_alu_op   = ex_r.alu_op;    e.ex_alusrc   = ex_r.alusrc;
    e.ex_branch   = ex_r.branch;    e.ex_brtype   = ex_r.brtype;
    e.mem_read    = mem_r.mem_read; e.mem_write   = mem_r.mem_write;
    e.mem_branch  = mem_r.branch;   e.wb_regwrite = wb_r.regwrite;
    e.wb_memtoreg = wb_r.memtoreg;  e.wb_dst      = wb_r.dst;
    e.id_jump     = st ? 0 : d.jump;
    e.pc_write    = st ? 0 : 1;
    e.ifid_write  = st ? 0 : 1;
    e.ifid_flush  = (bt || (d.jump != 0 && !st)) ? 1 : 0;
    e.illegal     = d.illegal;
    e.stall_cnt   = stall_m;
    e.flush_cnt   = flush_m;
    e.illegal_cnt = illegal_m;
    exp_q.push_back(e);
    last_stall = st;
    if (!in_reset) begin
      stall_m   += st ? 1 : 0;
      flush_m   += e.ifid_flush;
      illegal_m += (d.illegal != 0 && v) ? 1 : 0;
      wb_r  = mem_r;
      mem_r = bt ? bub : ex_r;
      ex_r  = (bt || st) ? bub : d;
    end
  endtask

  task automatic drive(input logic [31:0] ins, input bit v, input bit bt, input bit release_rst);
    @(posedge clk);
    #1;
    if (release_rst) begin
      rst_i    = 1'b1;
      in_reset = 1'b0;
    end
    instr_i        = ins;
    id_valid_i     = v;
    branch_taken_i = bt;
    evaluate(ins, v, bt);
  endtask

  task automatic clear_model();
    ex_r = '{default: 0};
    mem_r = '{default: 0};
    wb_r = '{default: 0};
    stall_m = 0;
    flush_m = 0;
    illegal_m = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ex_alu_op", int'(ex_alu_op_o), e.ex_alu_op);
        chk("ex_alusrc", int'(ex_alusrc_o), e.ex_alusrc);
        chk("ex_branch", int'(ex_branch_o), e.ex_branch);
        chk("ex_brtype", int'(ex_brtype_o), e.ex_brtype);
        chk("mem_read", int'(mem_read_o), e.mem_read);
        chk("mem_write", int'(mem_write_o), e.mem_write);
        chk("mem_branch", int'(mem_branch_o), e.mem_branch);
        chk("wb_regwrite", int'(wb_regwrite_o), e.wb_regwrite);
        chk("wb_memtoreg", int'(wb_memtoreg_o), e.wb_memtoreg);
        if (e.wb_regwrite != 0) chk("wb_dst", int'(wb_dst_o), e.wb_dst);
        chk("id_jump", int'(id_jump_o), e.id_jump);
        chk("pc_write", int'(pc_write_o), e.pc_write);
        chk("ifid_write", int'(ifid_write_o), e.ifid_write);
        chk("ifid_flush", int'(ifid_flush_o), e.ifid_flush);
        chk("illegal", int'(illegal_o), e.illegal);
`ifdef PIPE_CTRL_PERF_EN
        chk("stall_cnt", int'(stall_cnt_o), e.stall_cnt);
        chk("flush_cnt", int'(flush_cnt_o), e.flush_cnt);
        chk("illegal_cnt", int'(illegal_cnt_o), e.illegal_cnt);
`endif
      end
    end
  end

  initial begin : driver
    logic [31:0] cur;
    logic [5:0]  op6, fn6;
    logic [4:0]  rs5, rt5, rd5;
    bit          cv;
    tbl[0]  = '{'h00,  8,  2, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0};
    tbl[1]  = '{'h00, -1,  2, 0, 0, 0, 0, 0, 1, 0, 2, 0, 1, 1};
    tbl[2]  = '{'h08, -1,  0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0};
    tbl[3]  = '{'h0D, -1,  4, 1, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0};
    tbl[4]  = '{'h0F, -1,  5, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0};
    tbl[5]  = '{'h23, -1,  6, 1, 0, 0, 1, 0, 1, 1, 1, 0, 1, 0};
    tbl[6]  = '{'h2B, -1,  7, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1};
    tbl[7]  = '{'h04, -1,  1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1};
    tbl[8]  = '{'h05, -1,  3, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 1};
    tbl[9]  = '{'h07, -1, 10, 0, 1, 3, 0, 0, 0, 0, 0, 0, 1, 1};
    tbl[10] = '{'h06, -1, 11, 0, 1, 4, 0, 0, 0, 0, 0, 0, 1, 1};
    tbl[11] = '{'h02, -1,  8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    tbl[12] = '{'h03, -1,  9, 0, 0, 0, 0, 0, 1, 2, 3, 1, 0, 0};
    clear_model();
    rst_i = 1'b0;
    in_reset = 1'b1;
    instr_i = '0;
    id_valid_i = 1'b0;
    branch_taken_i = 1'b0;
    last_stall = 1'b0;

    drive(32'h0, 0, 0, 0);
    drive(32'h2008_0005, 1, 0, 1);   // ADDI $8,$0,5
    drive(32'h8D09_0000, 1, 0, 0);   // LW $9,0($8)
    drive(32'h0129_5020, 1, 0, 0);   // ADD $10,$9,$9 (stalls)
    drive(32'h0129_5020, 1, 0, 0);   // ADD re-presented
    drive(32'h0, 0, 0, 0);
    drive(32'h0, 0, 0, 0);
    drive(32'h8D09_0000, 1, 0, 0);   // LW $9
    drive(32'h0129_5020, 1, 1, 0);   // dependent ADD with taken branch
    drive(32'h0, 0, 0, 0);
    drive(32'h0C00_0010, 1, 0, 0);   // JAL 0x40
    drive(32'h0, 0, 0, 0);
    drive(32'h0, 0, 0, 0);
    drive(32'h0, 0, 0, 0);
    drive(32'hFC00_0000, 1, 0, 0);   // illegal opcode 0x3F
    drive(32'h0, 0, 0, 0);
    drive(32'h8C25_0000, 1, 0, 0);   // LW $5,0($1)
    drive(32'h0, 0, 0, 0);

    @(posedge clk);
    #1;
    instr_i = '0;
    id_valid_i = 1'b0;
    branch_taken_i = 1'b0;
    chk("pre_rst_mem_read", int'(mem_read_o), mem_r.mem_read);
    clear_model();
    in_reset = 1'b1;
    evaluate(32'h0, 0, 0);
    #2;
    rst_i = 1'b0;                    // asynchronous, mid-cycle
    drive(32'h0, 0, 0, 0);
    drive(32'h2008_0005, 1, 0, 1);

    for (int n = 0; n < 500; n++) begin
      if (!last_stall) begin
        op6 = 6'(ops[$urandom_range(0, 14)]);
        rs5 = 5'($urandom_range(0, 3));
        rt5 = 5'($urandom_range(0, 3));
        rd5 = 5'($urandom_range(0, 3));
        fn6 = ($urandom_range(0, 4) == 0) ? 6'h08 : 6'(32 + $urandom_range(0, 7));
        cur = {op6, rs5, rt5, rd5, 5'd0, fn6};
        cv  = ($urandom_range(0, 9) != 0);
      end
      drive(cur, cv, ($urandom_range(0, 9) == 0), 0);
    end
    drive(32'h0, 0, 0, 0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Control unit for the 5-stage pipelined MIPS core; successor to the single-cycle decoder.
- Decodes the ID-stage instruction (opcode plus funct) into a control bundle, then carries that bundle through ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and drives stall signals.
- Applies branch/jump flushes by inserting bubbles.

Parameters:
- ALU_OP_W, 5, width of ALU op code field
- BR_TYPE_W, 3, width of branch type field
- REG_AW, 5, register address width
- LINK_REG, 31, destination register for JAL

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  asynchronous active-low reset
- instr_i  in  32  instruction in ID stage (IF/ID register output)
- id_valid_i  in  1  ID instruction is valid; 0 decodes as bubble
- branch_taken_i  in  1  branch resolved taken in MEM stage
- ex_alu_op_o  out  ALU_OP_W  ALU op, EX stage
- ex_alusrc_o  out  1  0 = rt, 1 = immediate
- ex_branch_o  out  1  branch instruction in EX
- ex_brtype_o  out  BR_TYPE_W  1 BEQ, 2 BNE, 3 BLE, 4 BLT
- mem_read_o  out  1  load in MEM
- mem_write_o  out  1  store in MEM
- mem_branch_o  out  1  branch in MEM
- wb_regwrite_o  out  1  register write in WB
- wb_memtoreg_o  out  2  0 ALU, 1 memory, 2 PC+8
- wb_dst_o  out  REG_AW  write-back register
- id_jump_o  out  2  0 none, 1 J/JAL target, 2 JR
- pc_write_o  out  1  0 holds PC (stall)
- ifid_write_o  out  1  0 holds IF/ID (stall)
- ifid_flush_o  out  1  clear IF/ID on next edge
- illegal_o  out  1  ID opcode/funct unrecognised (combinational)

Behaviour:
- Reset (rst_i low, asynchronous): all pipeline control registers clear to 0. All registered outputs are 0. pc_write_o and ifid_write_o are 1 while in reset.
- Decode table, by opcode:
  - 0x00 R-type: alu_op 2, regdst rd, regwrite. funct 0x08 (JR): no regwrite, id_jump 2.
  - 0x08 ADDI: alu_op 0, alusrc 1, regwrite, dst rt.
  - 0x0D ORI: alu_op 4, alusrc 1, regwrite, dst rt.
  - 0x0F LUI: alu_op 5, alusrc 1, regwrite, dst rt.
  - 0x23 LW: alu_op 6, alusrc 1, mem_read, memtoreg 1, regwrite, dst rt.
  - 0x2B SW: alu_op 7, alusrc 1, mem_write.
  - 0x04 BEQ: alu_op 1, branch, brtype 1.
  - 0x05 BNE: alu_op 3, branch, brtype 2.
  - 0x07 BLE: alu_op 10, branch, brtype 3.
  - 0x06 BLT: alu_op 11, branch, brtype 4.
  - 0x02 J: alu_op 8, id_jump 1.
  - 0x03 JAL: alu_op 9, id_jump 1, regwrite, dst LINK_REG, memtoreg 2.
  - Any other opcode: illegal_o=1, all-zero bundle (bubble).
- Every opcode has exactly one table entry; there are no duplicate decodes.
- Any write to destination register 0 forces regwrite to 0.
- Source use:
  - uses_rs is set for all instructions except LUI, J, JAL.
  - uses_rt is set for R-type (excluding JR), SW and all branches.
- Load-use stall condition: ID/EX mem_read=1 and ex_dst!=0 and (ex_dst==rs with uses_rs, or ex_dst==rt with uses_rt), with id_valid_i=1. When it holds:
  - pc_write_o=0 and ifid_write_o=0.
  - A bubble is loaded into ID/EX.
  - Lasts exactly 1 cycle per hazard.
- Branch flush: branch_taken_i=1 loads bubbles into ID/EX and EX/MEM, and sets ifid_flush_o=1 in the same cycle.
- Flush has priority over stall: when both hold, stall outputs stay 1 and the flush is applied.
- Jump: a J/JAL/JR in ID with no stall sets ifid_flush_o=1 for that cycle. The jump itself still advances to ID/EX.
- Latency: ID decode reaches ex_* after 1 edge, mem_* after 2 edges, wb_* after 3 edges.
- Bubbles never assert regwrite, mem_read, mem_write, branch or jump.
- Reset asserted mid-pipeline clears all in-flight controls immediately; the first post-reset instruction proceeds normally.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- When defined, the block adds the following ports:
  - stall_cnt_o (out, 32): counts stall cycles.
  - flush_cnt_o (out, 32): counts cycles with ifid_flush_o=1.
  - illegal_cnt_o (out, 32): counts cycles with illegal_o and id_valid_i both 1.
- All three counters saturate at 0xFFFFFFFF and reset to 0.
- When the macro is undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- ADDI $8,$0,5 (0x20080005), valid, no hazards -> after 1 edge ex_alu_op_o=0, ex_alusrc_o=1. After 3 edges wb_regwrite_o=1, wb_dst_o=8, wb_memtoreg_o=0.
- LW $9,0($8), then ADD $10,$9,$9 -> 1 cycle with pc_write_o=0 and ifid_write_o=0, bubble in EX. ADD reaches EX on the following cycle. No second stall.
- BEQ in MEM with branch_taken_i=1 while a stall is pending -> ifid_flush_o=1, pc_write_o=1. Next cycle ex_* and mem_* are all 0.
- JAL 0x0000040 -> ifid_flush_o=1 in the ID cycle. 3 edges later wb_dst_o=31, wb_memtoreg_o=2, wb_regwrite_o=1.
- Opcode 0x3F valid -> illegal_o=1. The EX bundle is all zero after 1 edge. With PIPE_CTRL_PERF_EN defined, illegal_cnt_o increments to 1.
- rst_i pulsed low asynchronously mid-cycle with LW in MEM -> mem_read_o drops to 0 immediately. All wb_* outputs are 0.
